// File: rtl/axi_sram_slave_if_pkg.sv
// Shared AXI constants for the SRAM slave front end.
package axi_sram_slave_if_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'd2;

  // Only 32-bit INCR bursts are natively supported downstream.
  function automatic logic hdr_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_WORD) | (burst != BURST_INCR);
  endfunction
endpackage

// File: rtl/axi_sram_slave_if_rr_arb2.sv
// Two-requester round-robin arbiter; a tie goes to whichever side lost the last grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_req,
  input  logic wr_req,
  input  logic rd_take,
  input  logic wr_take,
  output logic rd_grant,
  output logic wr_grant
);
  logic last_was_rd;

  assign rd_grant = rd_req & (~wr_req | ~last_was_rd);
  assign wr_grant = wr_req & (~rd_req |  last_was_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_was_rd <= 1'b0;
    else if (rd_take) last_was_rd <= 1'b1;
    else if (wr_take) last_was_rd <= 1'b0;
  end
endmodule

// File: rtl/axi_sram_slave_if.sv
// AXI4 slave front end: turns one AXI burst at a time into an axi2sram request,
// passes data straight through and generates RLAST / B response.
module axi_sram_slave_if #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [AXI_AWIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [AXI_DWIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [AXI_AWIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  input  logic [AXI_DWIDTH-1:0] s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wlast,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [31:0]           rd_req_addr,
  output logic [31:0]           rd_req_len,
  output logic [2:0]            rd_req_size,
  output logic [1:0]            rd_req_burst,
  input  logic [31:0]           rd_data,
  input  logic                  rd_data_valid,
  output logic                  rd_data_ready,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [31:0]           wr_req_addr,
  output logic [31:0]           wr_req_len,
  output logic [2:0]            wr_req_size,
  output logic [1:0]            wr_req_burst,
  output logic [31:0]           wr_data,
  output logic                  wr_data_valid,
  input  logic                  wr_data_ready
);
  import axi_sram_slave_if_pkg::*;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_WR_RESP = 3'd5;

  logic [2:0]            state;
  logic                  rst_done, err;
  logic [7:0]            beat, len_q;
  logic [AXI_AWIDTH-1:0] addr_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  idle, rd_ph, wr_ph, rd_grant, wr_grant;
  logic                  ar_hs, aw_hs, r_hs, w_hs, last_beat;

  assign idle      = (state == S_IDLE);
  assign rd_ph     = (state == S_RD_DATA);
  assign wr_ph     = (state == S_WR_DATA);
  assign last_beat = (beat == len_q);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_req   (s_arvalid),
    .wr_req   (s_awvalid),
    .rd_take  (ar_hs),
    .wr_take  (aw_hs),
    .rd_grant (rd_grant),
    .wr_grant (wr_grant)
  );

  assign s_arready = idle & rd_grant & rst_done;
  assign s_awready = idle & wr_grant & rst_done;
  assign ar_hs     = s_arvalid & s_arready;
  assign aw_hs     = s_awvalid & s_awready;

  // Both request ports share the captured header; only one is ever valid.
  assign rd_req_valid = (state == S_RD_REQ);
  assign wr_req_valid = (state == S_WR_REQ);
  assign rd_req_addr  = 32'(addr_q);
  assign wr_req_addr  = 32'(addr_q);
  assign rd_req_len   = {24'd0, len_q};
  assign wr_req_len   = {24'd0, len_q};
  assign rd_req_size  = size_q;
  assign wr_req_size  = size_q;
  assign rd_req_burst = burst_q;
  assign wr_req_burst = burst_q;

  assign s_rvalid      = rd_ph & rd_data_valid;
  assign rd_data_ready = rd_ph & s_rready;
  assign s_rdata       = rd_data;
  assign s_rlast       = rd_ph & last_beat;
  assign s_rresp       = (rd_ph & err) ? RESP_SLVERR : RESP_OKAY;
  assign r_hs          = s_rvalid & s_rready;

  assign s_wready      = wr_ph & wr_data_ready;
  assign wr_data_valid = wr_ph & s_wvalid;
  assign wr_data       = s_wdata;
  assign w_hs          = s_wvalid & s_wready;

  assign s_bvalid = (state == S_WR_RESP);
  assign s_bresp  = (s_bvalid & err) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rst_done <= 1'b0;
      err      <= 1'b0;
      beat     <= 8'd0;
      addr_q   <= '0;
      len_q    <= 8'd0;
      size_q   <= 3'd0;
      burst_q  <= 2'd0;
    end else begin
      rst_done <= 1'b1;
      case (state)
        S_IDLE: if (ar_hs | aw_hs) begin
          state   <= ar_hs ? S_RD_REQ : S_WR_REQ;
          addr_q  <= ar_hs ? s_araddr  : s_awaddr;
          len_q   <= ar_hs ? s_arlen   : s_awlen;
          size_q  <= ar_hs ? s_arsize  : s_awsize;
          burst_q <= ar_hs ? s_arburst : s_awburst;
          err     <= ar_hs ? hdr_err(s_arsize, s_arburst) : hdr_err(s_awsize, s_awburst);
          beat    <= 8'd0;
        end
        S_RD_REQ:  if (rd_req_ready) state <= S_RD_DATA;
        // The counter holds on the final beat so len=255 never wraps.
        S_RD_DATA: if (r_hs) begin
          if (last_beat) state <= S_IDLE;
          else           beat  <= beat + 8'd1;
        end
        S_WR_REQ:  if (wr_req_ready) state <= S_WR_DATA;
        S_WR_DATA: if (w_hs) begin
          if ((s_wstrb != 4'hF) || (s_wlast != last_beat)) err <= 1'b1;
          if (last_beat) state <= S_WR_RESP;
          else           beat  <= beat + 8'd1;
        end
        S_WR_RESP: if (s_bready) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_sram_slave_if.sv
// Randomized bench for axi_sram_slave_if: an axi2sram/SRAM model, a master model,
// and a transaction-level scoreboard of expected requests, beats and responses.
module tb_axi_sram_slave_if;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_arvalid = 0, s_arready;
  logic [31:0] s_araddr = 0;
  logic [7:0]  s_arlen = 0;
  logic [2:0]  s_arsize = 0;
  logic [1:0]  s_arburst = 0;
  logic        s_rvalid, s_rready = 0, s_rlast;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_awvalid = 0, s_awready;
  logic [31:0] s_awaddr = 0;
  logic [7:0]  s_awlen = 0;
  logic [2:0]  s_awsize = 0;
  logic [1:0]  s_awburst = 0;
  logic        s_wvalid = 0, s_wready, s_wlast = 0;
  logic [31:0] s_wdata = 0;
  logic [3:0]  s_wstrb = 0;
  logic        s_bvalid, s_bready = 0;
  logic [1:0]  s_bresp;
  logic        rd_req_valid, rd_req_ready = 0;
  logic [31:0] rd_req_addr, rd_req_len;
  logic [2:0]  rd_req_size;
  logic [1:0]  rd_req_burst;
  logic [31:0] rd_data = 0;
  logic        rd_data_valid = 0, rd_data_ready;
  logic        wr_req_valid, wr_req_ready = 0;
  logic [31:0] wr_req_addr, wr_req_len;
  logic [2:0]  wr_req_size;
  logic [1:0]  wr_req_burst;
  logic [31:0] wr_data;
  logic        wr_data_valid, wr_data_ready = 0;

  axi_sram_slave_if #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_req_size(rd_req_size), .rd_req_burst(rd_req_burst),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_len(wr_req_len), .wr_req_size(wr_req_size), .wr_req_burst(wr_req_burst),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready)
  );

  typedef struct packed {logic [31:0] d; logic l; logic [1:0] r;} rbeat_t;
  typedef struct packed {logic [31:0] a; logic [7:0] len; logic [2:0] sz; logic [1:0] bu;} req_t;
  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} wbeat_t;

  logic [31:0] mem [0:1023];
  rbeat_t      exp_r[$], rlog[$];
  req_t        exp_rq[$], exp_wq[$];
  logic [1:0]  exp_b[$], blog[$];
  wbeat_t      wq[$], tw[$];
  int          chk_a[$];
  logic [31:0] chk_d[$];
  int          n_tests = 0, n_fail = 0, tie_first;
  bit          b_hold = 0, last_rd = 0;

  bit          m_rd_act = 0, m_wr_act = 0;
  logic [31:0] m_rd_base, m_wr_base;
  int          m_rd_idx, m_rd_tot, m_wr_idx, m_wr_tot;

  function automatic int widx(input logic [31:0] a, input int i);
    return int'(((a >> 2) + 32'(i)) & 32'd1023);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    n_tests++; n_fail++;
    $display("FAIL %s: got no/extra DUT event, expected exactly the modelled one", nm);
  endtask

  // axi2sram + SRAM model on the request side, AXI master on R/W/B.
  initial begin : env
    bit rd_hs, wd_hs, w_hs;
    forever begin
      @(negedge clk);
      rd_hs = rd_data_valid && rd_data_ready;
      wd_hs = wr_data_valid && wr_data_ready;
      w_hs  = s_wvalid && s_wready;
      if (!rst_n) begin
        m_rd_act = 0; m_wr_act = 0; rd_hs = 0; wd_hs = 0; w_hs = 0;
      end else begin
        if (rd_req_valid && rd_req_ready) begin
          m_rd_act = 1; m_rd_base = rd_req_addr; m_rd_idx = 0; m_rd_tot = int'(rd_req_len) + 1;
        end
        if (rd_hs) begin m_rd_idx++; if (m_rd_idx >= m_rd_tot) m_rd_act = 0; end
        if (wr_req_valid && wr_req_ready) begin
          m_wr_act = 1; m_wr_base = wr_req_addr; m_wr_idx = 0; m_wr_tot = int'(wr_req_len) + 1;
        end
        if (wd_hs) begin
          mem[widx(m_wr_base, m_wr_idx)] = wr_data;
          m_wr_idx++; if (m_wr_idx >= m_wr_tot) m_wr_act = 0;
        end
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        rd_req_ready = 0; wr_req_ready = 0; rd_data_valid = 0; rd_data = 0; wr_data_ready = 0;
        s_rready = 0; s_bready = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0;
      end else begin
        rd_req_ready = 1'($urandom_range(0, 1));
        wr_req_ready = 1'($urandom_range(0, 1));
        // SRAM side delivers at most one beat per two clocks.
        if (rd_data_valid && rd_hs) rd_data_valid = 0;
        else if (!rd_data_valid && m_rd_act) begin
          rd_data_valid = 1; rd_data = mem[widx(m_rd_base, m_rd_idx)];
        end
        wr_data_ready = m_wr_act && !wd_hs && ($urandom_range(0, 2) != 0);
        s_rready = ($urandom_range(0, 3) != 0);
        s_bready = !b_hold && ($urandom_range(0, 1) != 0);
        if (w_hs && wq.size() > 0) void'(wq.pop_front());
        if (!s_wvalid || w_hs) begin
          s_wvalid = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
          if (wq.size() > 0) begin s_wdata = wq[0].d; s_wstrb = wq[0].s; s_wlast = wq[0].l; end
        end
      end
    end
  end

  // Scoreboard: every request, R beat and B response against the expected queues.
  initial begin : cmp
    int w_cnt = 0, w_tot = 0;
    bit pend_b = 0;
    rbeat_t eb;
    req_t er;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pend_b = 0; w_cnt = 0; w_tot = 0; continue; end
      if (pend_b) begin chk("b_latency", s_bvalid, 1'b1); pend_b = 0; end
      if (rd_req_valid && rd_req_ready) begin
        if (exp_rq.size() == 0) fail_msg("rd_req_unexpected");
        else begin
          er = exp_rq.pop_front();
          chk("rd_req", {rd_req_addr, rd_req_len, rd_req_size, rd_req_burst}, {er.a, 24'd0, er.len, er.sz, er.bu});
        end
      end
      if (wr_req_valid && wr_req_ready) begin
        if (exp_wq.size() == 0) fail_msg("wr_req_unexpected");
        else begin
          er = exp_wq.pop_front();
          chk("wr_req", {wr_req_addr, wr_req_len, wr_req_size, wr_req_burst}, {er.a, 24'd0, er.len, er.sz, er.bu});
          w_tot = int'(er.len) + 1; w_cnt = 0;
        end
      end
      if (s_wvalid && s_wready) begin
        w_cnt++;
        if (w_cnt == w_tot) pend_b = 1;
      end
      if (s_rvalid && s_rready) begin
        rlog.push_back('{s_rdata, s_rlast, s_rresp});
        if (exp_r.size() == 0) fail_msg("r_beat_unexpected");
        else begin
          eb = exp_r.pop_front();
          chk("r_beat", {s_rdata, s_rlast, s_rresp}, eb);
        end
      end
      if (s_bvalid && s_bready) begin
        blog.push_back(s_bresp);
        if (exp_b.size() == 0) fail_msg("b_unexpected");
        else chk("bresp", s_bresp, exp_b.pop_front());
      end
    end
  end

  task automatic push_rd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    logic [1:0] r;
    r = (sz != 3'd2 || bu != 2'b01) ? 2'b10 : 2'b00;
    exp_rq.push_back('{a, len, sz, bu});
    for (int i = 0; i <= int'(len); i++) exp_r.push_back('{mem[widx(a, i)], (i == int'(len)), r});
    s_araddr = a; s_arlen = len; s_arsize = sz; s_arburst = bu;
  endtask

  // Beats come from tw; partial strobes still land as full words.
  task automatic push_wr(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    bit e;
    e = (sz != 3'd2 || bu != 2'b01);
    exp_wq.push_back('{a, len, sz, bu});
    foreach (tw[i]) begin
      if (tw[i].s != 4'hF || tw[i].l != (i == int'(len))) e = 1;
      wq.push_back(tw[i]);
      chk_a.push_back(widx(a, i));
      chk_d.push_back(tw[i].d);
    end
    exp_b.push_back(e ? 2'b10 : 2'b00);
    tw.delete();
    s_awaddr = a; s_awlen = len; s_awsize = sz; s_awburst = bu;
  endtask

  task automatic go(input bit dr, input bit dw);
    bit ar_done, aw_done, a, w, both;
    int lat = 0, cyc = 0;
    ar_done = !dr; aw_done = !dw; tie_first = -1;
    if (dr) s_arvalid = 1;
    if (dw) s_awvalid = 1;
    while (!(ar_done && aw_done) && cyc < 3000) begin
      @(negedge clk);
      if (lat == 1) chk("rd_req_latency", rd_req_valid, 1'b1);
      if (lat == 2) chk("wr_req_latency", wr_req_valid, 1'b1);
      lat = 0;
      a = s_arvalid && s_arready; w = s_awvalid && s_awready;
      both = s_arvalid && s_awvalid;
      if (a || w) begin
        chk("grant_exclusive", a && w, 1'b0);
        if (both) begin
          chk("tie_grant", a, !last_rd);
          if (tie_first < 0) tie_first = a ? 1 : 0;
        end
        last_rd = a;
        lat = a ? 1 : 2;
      end
      @(posedge clk); #1;
      if (a) begin s_arvalid = 0; ar_done = 1; end
      if (w) begin s_awvalid = 0; aw_done = 1; end
      cyc++;
    end
    if (lat != 0) begin
      @(negedge clk);
      chk(lat == 1 ? "rd_req_latency" : "wr_req_latency", lat == 1 ? rd_req_valid : wr_req_valid, 1'b1);
      @(posedge clk); #1;
    end
    if (!(ar_done && aw_done)) begin
      fail_msg("addr_handshake_timeout");
      s_arvalid = 0; s_awvalid = 0;
    end
  endtask

  task automatic flush();
    exp_r.delete(); exp_rq.delete(); exp_wq.delete(); exp_b.delete();
    wq.delete(); tw.delete(); chk_a.delete(); chk_d.delete();
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((exp_r.size() + exp_b.size() + exp_rq.size() + exp_wq.size() + wq.size()) != 0 && c < 6000) begin
      @(posedge clk); #1; c++;
    end
    if (c >= 6000) begin fail_msg("completion_timeout"); flush(); end
    repeat (2) @(posedge clk); #1;
    while (chk_a.size() > 0) chk("sram_word", mem[chk_a.pop_front()], chk_d.pop_front());
  endtask

  task automatic do_reset();
    rst_n = 0; s_arvalid = 0; s_awvalid = 0;
    flush(); last_rd = 0; b_hold = 0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(nm, {s_arready, s_awready, s_rvalid, s_rlast, s_rresp, s_wready, s_bvalid, s_bresp,
             rd_req_valid, rd_data_ready, wr_req_valid, wr_data_valid}, 14'd0);
  endtask

  task automatic rand_rd();
    logic [7:0] len;
    len = 8'($urandom_range(0, 15));
    push_rd(32'($urandom_range(0, 400)) * 4, len,
            ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01);
  endtask

  task automatic rand_wr();
    logic [7:0] len;
    len = 8'($urandom_range(0, 15));
    for (int i = 0; i <= int'(len); i++)
      tw.push_back('{$urandom, ($urandom_range(0, 9) == 0) ? 4'h7 : 4'hF,
                     (i == int'(len)) ^ ($urandom_range(0, 11) == 0)});
    push_wr(32'(600 + $urandom_range(0, 200)) * 4, len,
            ($urandom_range(0, 7) == 0) ? 3'd0 : 3'd2, ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nl;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1;

    // Single read, data 0xA0..0xA3.
    for (int i = 0; i < 4; i++) mem[16'h40 + i] = 32'hA0 + 32'(i);
    rlog.delete();
    push_rd(32'h100, 8'd3, 3'd2, 2'b01);
    go(1, 0); wait_idle();
    chk("t1_beats", rlog.size(), 4);
    if (rlog.size() == 4)
      for (int i = 0; i < 4; i++) chk("t1_beat_lit", rlog[i], {32'hA0 + 32'(i), (i == 3), 2'b00});

    // Write with B backpressure.
    b_hold = 1; blog.delete();
    tw.push_back('{32'h11112222, 4'hF, 1'b0});
    tw.push_back('{32'h33334444, 4'hF, 1'b1});
    push_wr(32'h40, 8'd1, 3'd2, 2'b01);
    go(0, 1);
    for (int c = 0; c < 500 && !s_bvalid; c++) @(negedge clk);
    if (!s_bvalid) fail_msg("bvalid_timeout");
    repeat (5) begin @(negedge clk); chk("bvalid_held", s_bvalid, 1'b1); end
    @(posedge clk); #1; b_hold = 0;
    wait_idle();
    chk("t2_word0", mem[16], 32'h11112222);
    chk("t2_word1", mem[17], 32'h33334444);
    if (blog.size() > 0) chk("t2_bresp", blog[0], 2'b00); else fail_msg("t2_no_bresp");

    // Two simultaneous AR/AW ties.
    for (int t = 0; t < 2; t++) begin
      push_rd(32'h180, 8'd1, 3'd2, 2'b01);
      tw.push_back('{$urandom, 4'hF, 1'b0});
      tw.push_back('{$urandom, 4'hF, 1'b1});
      push_wr(32'h800, 8'd1, 3'd2, 2'b01);
      go(1, 1);
      chk("tie_read_first", tie_first, 1);
      wait_idle();
    end

    // Error responses.
    blog.delete();
    tw.push_back('{32'hCAFE0001, 4'h3, 1'b1});
    push_wr(32'hC00, 8'd0, 3'd2, 2'b01);
    go(0, 1); wait_idle();
    if (blog.size() == 1) chk("strb_slverr", blog[0], 2'b10); else fail_msg("strb_no_bresp");
    blog.delete();
    tw.push_back('{32'hBEEF0000, 4'hF, 1'b1});
    tw.push_back('{32'hBEEF0001, 4'hF, 1'b0});
    tw.push_back('{32'hBEEF0002, 4'hF, 1'b0});
    push_wr(32'hC40, 8'd2, 3'd2, 2'b01);
    go(0, 1); wait_idle();
    if (blog.size() == 1) chk("early_wlast_slverr", blog[0], 2'b10); else fail_msg("early_wlast_no_bresp");
    chk("early_wlast_word2", mem[widx(32'hC40, 2)], 32'hBEEF0002);
    rlog.delete();
    push_rd(32'h140, 8'd3, 3'd2, 2'b00);
    go(1, 0); wait_idle();
    chk("fixed_beats", rlog.size(), 4);
    foreach (rlog[i]) chk("fixed_rresp", rlog[i].r, 2'b10);

    // Reset in the middle of an 8-beat read.
    rlog.delete();
    push_rd(32'h200, 8'd7, 3'd2, 2'b01);
    go(1, 0);
    for (int c = 0; c < 300 && rlog.size() < 2; c++) begin @(posedge clk); #1; end
    chk("pre_reset_beats", rlog.size(), 2);
    #1; rst_n = 0;
    #1; chk_reset_outs("mid_burst_reset");
    do_reset();
    rlog.delete();
    push_rd(32'h300, 8'd0, 3'd2, 2'b01);
    go(1, 0); wait_idle();
    chk("len0_beats", rlog.size(), 1);
    if (rlog.size() == 1) chk("len0_rlast", rlog[0].l, 1'b1);

    // Longest burst.
    rlog.delete();
    push_rd(32'h0, 8'd255, 3'd2, 2'b01);
    go(1, 0); wait_idle();
    chk("len255_beats", rlog.size(), 256);
    nl = 0;
    foreach (rlog[i]) if (rlog[i].l) nl++;
    chk("len255_rlast_count", nl, 1);
    if (rlog.size() == 256) chk("len255_rlast_pos", rlog[255].l, 1'b1);

    // Random mix, including ties.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0: begin rand_rd(); go(1, 0); end
        1: begin rand_wr(); go(0, 1); end
        default: begin rand_rd(); rand_wr(); go(1, 1); end
      endcase
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
